pixel_readout: RTL

PIXEL_READOUT -- requirements
Module: pixel_readout

---
 rtl/pixel_readout.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_readout.sv
// Pixel array readout sequencer.
// Watches the controller's read_1/read_2 strobes, samples each 16-bit data bus
// once it has been stable for SETTLE rising edges, and pushes the assembled
// {data_2, data_1} word into a small output FIFO. Short strobes and dropped
// words are reported through sticky error flags.
module pixel_readout #(
  parameter int SETTLE = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        erase,
  input  logic        read_1,
  input  logic        read_2,
  input  logic [15:0] data_1,
  input  logic [15:0] data_2,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  level,
  output logic        overflow,
  output logic        short_err,
  input  logic        clr_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic [4:0] DEPTH_C  = 5'(DEPTH);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] R1   = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] R2   = 3'd3;
  localparam logic [2:0] PUSH = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, cnt_inc;
  logic [15:0] lo_q, lo_nxt, hi_q, hi_nxt;
  logic        lo_vld, lo_vld_nxt, hi_vld, hi_vld_nxt;
  logic        push_req, short_set;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, wr_en, ovf_set;

  // Strobe sequencing: count stable strobe edges, latch each half once, then push.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lo_nxt     = lo_q;
    hi_nxt     = hi_q;
    lo_vld_nxt = lo_vld;
    hi_vld_nxt = hi_vld;
    push_req   = 1'b0;
    short_set  = 1'b0;
    cnt_inc    = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;

    case (state)
      IDLE: begin
        if (read_1) begin
          state_nxt  = R1;
          cnt_nxt    = 4'd1;
          lo_vld_nxt = (SETTLE_C == 4'd1);
          if (SETTLE_C == 4'd1) lo_nxt = data_1;
        end
      end
      R1: begin
        if (read_1) begin
          cnt_nxt = cnt_inc;
          // lo_vld guard keeps a saturated counter from re-latching.
          if (!lo_vld && cnt_inc == SETTLE_C) begin
            lo_nxt     = data_1;
            lo_vld_nxt = 1'b1;
          end
        end else if (lo_vld) begin
          state_nxt = GAP;
        end else begin
          state_nxt = IDLE;
          short_set = 1'b1;
        end
      end
      GAP: begin
        if (read_2) begin
          state_nxt  = R2;
          cnt_nxt    = 4'd1;
          hi_vld_nxt = (SETTLE_C == 4'd1);
          if (SETTLE_C == 4'd1) hi_nxt = data_2;
        end else if (read_1) begin
          // Controller restarted the row: the earlier low half is stale.
          state_nxt  = R1;
          cnt_nxt    = 4'd1;
          lo_vld_nxt = (SETTLE_C == 4'd1);
          lo_nxt     = (SETTLE_C == 4'd1) ? data_1 : 16'd0;
        end
      end
      R2: begin
        if (read_2) begin
          cnt_nxt = cnt_inc;
          if (!hi_vld && cnt_inc == SETTLE_C) begin
            hi_nxt     = data_2;
            hi_vld_nxt = 1'b1;
          end
        end else if (hi_vld) begin
          state_nxt = PUSH;
        end else begin
          state_nxt  = IDLE;
          short_set  = 1'b1;
          lo_vld_nxt = 1'b0;
        end
      end
      PUSH: begin
        push_req   = 1'b1;
        state_nxt  = IDLE;
        lo_vld_nxt = 1'b0;
        hi_vld_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    // Frame-start marker overrides everything, including a pending push.
    if (erase) begin
      state_nxt  = IDLE;
      cnt_nxt    = 4'd0;
      lo_nxt     = 16'd0;
      hi_nxt     = 16'd0;
      lo_vld_nxt = 1'b0;
      hi_vld_nxt = 1'b0;
      push_req   = 1'b0;
      short_set  = 1'b0;
    end
  end

  // FIFO control: a full FIFO still accepts a word when the head leaves this cycle.
  always_comb begin
    pop       = out_valid & out_ready;
    full      = (level == DEPTH_C);
    wr_en     = push_req & (~full | pop);
    ovf_set   = push_req & full & ~pop;
    out_valid = (level != 5'd0);
    out_data  = out_valid ? mem[rd_ptr] : 32'd0;
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      lo_q   <= 16'd0;
      hi_q   <= 16'd0;
      lo_vld <= 1'b0;
      hi_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      lo_q   <= lo_nxt;
      hi_q   <= hi_nxt;
      lo_vld <= lo_vld_nxt;
      hi_vld <= hi_vld_nxt;
    end
  end

  // FIFO storage; output is masked while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {hi_q, lo_q};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      short_err <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (short_set)    short_err <= 1'b1;
      else if (clr_err) short_err <= 1'b0;
    end
  end

endmodule
